// File: rtl/weight_loader_if.sv
// Weight byte stream handshake plus the shared bank write port driven by weight_loader.
interface weight_loader_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [NUM_BANKS-1:0]  bank_csen;
  logic                  bank_wren;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0] bank_data;

  modport master (
    output s_data, s_valid,
    input  s_ready, bank_csen, bank_wren, bank_addr, bank_data
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, bank_csen, bank_wren, bank_addr, bank_data
  );
endinterface

// File: rtl/weight_loader.sv
// Weight-fill engine: de-interleaves a byte stream round-robin into NUM_BANKS bank write ports.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds a 16-bit running byte sum on the checksum output.
module weight_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            layer_id,
  input  logic [ADDR_WIDTH:0]   words_per_bank,
  weight_loader_if.slave        bus,
  output logic [3:0]            layer2weight_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned K_WIDTH   = ADDR_WIDTH + BANK_BITS + 1;
  localparam int unsigned N_WIDTH   = ADDR_WIDTH + 1;
  localparam logic [N_WIDTH-1:0] DEPTH = N_WIDTH'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state;
  logic [K_WIDTH-1:0] k;
  logic [K_WIDTH-1:0] last_k;
  logic [N_WIDTH-1:0] n_clamp;
  logic               beat;

  // Requests larger than a bank are clamped to the bank depth.
  assign n_clamp = (words_per_bank > DEPTH) ? DEPTH : words_per_bank;
  assign beat    = bus.s_valid && bus.s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      k                <= '0;
      last_k           <= '0;
      bus.s_ready      <= 1'b0;
      bus.bank_csen    <= '0;
      bus.bank_wren    <= 1'b0;
      bus.bank_addr    <= '0;
      bus.bank_data    <= DATA_WIDTH'(0);
      layer2weight_cnt <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      bus.bank_csen <= '0;
      bus.bank_wren <= 1'b0;
      bus.bank_addr <= '0;
      bus.bank_data <= DATA_WIDTH'(0);
      done          <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            layer2weight_cnt <= layer_id;
            k                <= '0;
            last_k           <= (K_WIDTH'(n_clamp) << BANK_BITS) - K_WIDTH'(1);
            busy             <= 1'b1;
            if (n_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= LOAD;
              bus.s_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            // Low bits of the beat count pick the bank, the rest the address.
            bus.bank_wren <= 1'b1;
            bus.bank_csen <= NUM_BANKS'(1) << k[BANK_BITS-1:0];
            bus.bank_addr <= k[BANK_BITS +: ADDR_WIDTH];
            bus.bank_data <= bus.s_data;
            k             <= k + K_WIDTH'(1);
            if (k == last_k) begin
              state       <= DONE;
              bus.s_ready <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state == IDLE && start) begin
      sum_q <= '0;
    end else if (beat) begin
      sum_q <= sum_q + 16'(bus.s_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule
